// File: rtl/adc_stream_reader.sv
// Drains packed ADC channel-pair words from the dual-clock FIFO into fixed-length AXI4-Stream packets.
// Define ADC_OVR_FLAG_EN to add per-channel full-scale flags on m_axis_tuser_o.
module adc_stream_reader #(
  parameter int AdcRes = 14,
  parameter int PktLen = 256,
  parameter int CntW   = 16
) (
  input  logic            clk_sys_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            fifo_empty_i,
  output logic            fifo_rd_en_o,
  input  logic [31:0]     fifo_dout_i,
  output logic [31:0]     m_axis_tdata_o,
  output logic            m_axis_tvalid_o,
  input  logic            m_axis_tready_i,
  output logic            m_axis_tlast_o,
  output logic [1:0]      m_axis_tuser_o,
  output logic [CntW-1:0] pkt_count_o,
  output logic            fmt_err_o,
  output logic            busy_o
);
  localparam int BW = $clog2(PktLen);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q;
  logic          inflight_q;
  logic [1:0]    occ_q;
  logic          wr_ptr_q, rd_ptr_q;
  logic [31:0]   data_q [2];
  logic [1:0]    last_q;

  logic       push, pop, last_in, stopping, reserved, pkt_closed, fmt_ok;
  logic [2:0] credit_used;

  assign push     = inflight_q;
  assign pop      = m_axis_tvalid_o & m_axis_tready_i;
  assign last_in  = (beat_q == BW'(PktLen - 1));
  assign stopping = (state_q == STOP) | ((state_q == RUN) & ~enable_i);

  // beat_q==0 with nothing in flight means the current packet is fully pushed (or never started).
  assign pkt_closed = (beat_q == '0) & ~inflight_q;
  assign reserved   = stopping & (pkt_closed | (inflight_q & last_in));

  // A beat leaving this cycle frees its slot immediately, which keeps 1 beat/clock with 2 entries.
  assign credit_used  = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign fifo_rd_en_o = (state_q != IDLE) & ~fifo_empty_i & (credit_used < 3'd2) & ~reserved;

  // Upper bits of each half, including the sign bit, must all match.
  assign fmt_ok = ((&fifo_dout_i[15:AdcRes-1]) | ~(|fifo_dout_i[15:AdcRes-1])) &
                  ((&fifo_dout_i[31:15+AdcRes]) | ~(|fifo_dout_i[31:15+AdcRes]));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable_i) state_d = RUN;
      RUN:  if (!enable_i) state_d = (pkt_closed && occ_q == 2'd0) ? IDLE : STOP;
      STOP: begin
        if (enable_i)
          state_d = RUN;
        else if (pkt_closed && (occ_q == 2'd0 || (occ_q == 2'd1 && pop)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      data_q      <= '{default: '0};
      last_q      <= '0;
      pkt_count_o <= '0;
      fmt_err_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en_o;
      occ_q      <= occ_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
        data_q[wr_ptr_q] <= fifo_dout_i;
        last_q[wr_ptr_q] <= last_in;
        wr_ptr_q         <= ~wr_ptr_q;
        beat_q           <= last_in ? '0 : beat_q + 1'b1;
        if (!fmt_ok) fmt_err_o <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (m_axis_tlast_o) pkt_count_o <= pkt_count_o + 1'b1;
      end
    end
  end

`ifdef ADC_OVR_FLAG_EN
  localparam logic [15:0] PosMax = 16'((1 << (AdcRes - 1)) - 1);
  localparam logic [15:0] NegMax = ~PosMax;

  logic [1:0] user_q [2];
  logic [1:0] user_in;

  assign user_in = {(fifo_dout_i[31:16] == PosMax) | (fifo_dout_i[31:16] == NegMax),
                    (fifo_dout_i[15:0]  == PosMax) | (fifo_dout_i[15:0]  == NegMax)};

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i)     user_q <= '{default: '0};
    else if (push) user_q[wr_ptr_q] <= user_in;
  end

  assign m_axis_tuser_o = user_q[rd_ptr_q];
`else
  assign m_axis_tuser_o = 2'b00;
`endif

  assign m_axis_tvalid_o = (occ_q != 2'd0);
  assign m_axis_tdata_o  = data_q[rd_ptr_q];
  assign m_axis_tlast_o  = last_q[rd_ptr_q];
  assign busy_o          = (state_q != IDLE);

endmodule
